// File: rtl/tick_rate_ctrl.sv
// Two-channel tick divider with run/stop control and glitch-free rate switching.
// Divisor changes and channel switches are applied only on tick (wrap) boundaries.
module tick_rate_ctrl #(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [WIDTH-1:0]     DIV_A_INIT = WIDTH'(4),
  parameter logic [WIDTH-1:0]     DIV_B_INIT = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             select,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             tick_a,
  output logic             tick_b,
  output logic             tick_out,
  output logic             active_sel,
  output logic             switch_pend,
  output logic [15:0]      tick_count
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] shd_a_q, shd_a_d;
  logic [WIDTH-1:0] shd_b_q, shd_b_d;
  logic             act_q, act_d;
  logic [15:0]      count_q, count_d;

  logic running;
  logic do_switch;
  logic restart_a, restart_b;
  logic reload_a, reload_b;
  logic we_a, we_b;

  always_comb begin
    running     = (state_q == StRun);
    tick_a      = running && (cnt_a_q == div_a_q);
    tick_b      = running && (cnt_b_q == div_b_q);
    tick_out    = act_q ? tick_b : tick_a;
    switch_pend = running && (select != act_q);
    // tick_out is the active channel's wrap, so a pending switch lands exactly on it
    do_switch   = switch_pend && tick_out;
    restart_a   = do_switch && !select;
    restart_b   = do_switch && select;
    reload_a    = tick_a || restart_a;
    reload_b    = tick_b || restart_b;
    we_a        = cfg_we && !cfg_sel;
    we_b        = cfg_we && cfg_sel;
  end

  assign active_sel = act_q;
  assign tick_count = count_q;

  always_comb begin
    state_d = state_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    shd_a_d = shd_a_q;
    shd_b_d = shd_b_q;
    act_d   = act_q;
    count_d = count_q + 16'(tick_out);

    case (state_q)
      StIdle: begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        act_d   = select;
        // Idle writes go live immediately; shadow follows so a later wrap reloads the same value
        if (we_a) begin
          div_a_d = cfg_data;
          shd_a_d = cfg_data;
        end
        if (we_b) begin
          div_b_d = cfg_data;
          shd_b_d = cfg_data;
        end
        if (run) state_d = StRun;
      end

      StRun: begin
        if (we_a) shd_a_d = cfg_data;
        if (we_b) shd_b_d = cfg_data;

        if (reload_a) div_a_d = we_a ? cfg_data : shd_a_q;
        if (reload_b) div_b_d = we_b ? cfg_data : shd_b_q;

        cnt_a_d = reload_a ? '0 : cnt_a_q + WIDTH'(1);
        cnt_b_d = reload_b ? '0 : cnt_b_q + WIDTH'(1);

        if (do_switch) act_d = select;

        if (!run) begin
          state_d = StIdle;
          cnt_a_d = '0;
          cnt_b_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_a_d = '0;
        cnt_b_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      div_a_q <= DIV_A_INIT;
      div_b_q <= DIV_B_INIT;
      shd_a_q <= DIV_A_INIT;
      shd_b_q <= DIV_B_INIT;
      act_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      shd_a_q <= shd_a_d;
      shd_b_q <= shd_b_d;
      act_q   <= act_d;
      count_q <= count_d;
    end
  end

endmodule
